// File: rtl/uart_pkg.sv
// Shared UART definitions (line levels, frame width, FSM states), also used by the receive side.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..B-1 (B = 2*CLK_PER_HALF_BIT) and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick is registered from the next count so it is high exactly while cnt_q == B-1
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              txd
);

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(DATA_W - 1);
  localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_W-1:0]     shreg_q, shreg_d;
  logic [BIT_IDX_W-1:0]  idx_q, idx_d;
  logic                  txd_q, txd_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign accept = tx_valid & ready_q;

  uart_baud_tick #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (bit_end)
  );

  // idx_q counts data bits in S_DATA and is reused to count stop bits in S_STOP
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    txd_d    = txd_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        txd_d = LINE_STOP;
        if (accept) begin
          state_d  = S_START;
          shreg_d  = tx_data;
          idx_d    = '0;
          txd_d    = LINE_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = parity_q;
`else
            state_d = S_STOP;
            txd_d   = LINE_STOP;
`endif
          end else begin
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
            idx_d   = idx_q + BIT_IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = LINE_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + BIT_IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = LINE_STOP;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      txd_q    <= LINE_STOP;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (STOP_BITS 1 and 2) against a frame-level model and a line receiver.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int HALF = 4;
  localparam int B    = 2 * HALF;
`ifdef UART_TX_PARITY_EN
  localparam int PAR   = 1;
  localparam int DONE0 = 89;
  localparam int DONE1 = 97;
`else
  localparam int PAR   = 0;
  localparam int DONE0 = 81;
  localparam int DONE1 = 89;
`endif

  logic              clk = 1'b0;
  logic [1:0]        rst_v;
  logic [1:0]        valid_v;
  logic [1:0][7:0]   data_v;
  logic [1:0]        ready_v;
  logic [1:0]        done_v;
  logic [1:0]        txd_v;

  always #5 clk = ~clk;

  uart_tx #(.CLK_PER_HALF_BIT(HALF), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_done(done_v[0]), .txd(txd_v[0]));

  uart_tx #(.CLK_PER_HALF_BIT(HALF), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_done(done_v[1]), .txd(txd_v[1]));

  int checks = 0;
  int errors = 0;

  task automatic check_v(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  int         edge_n = 0;
  bit         chk_en  [2] = '{0, 0};
  bit         m_in    [2] = '{0, 0};
  int         m_t     [2] = '{0, 0};
  logic [7:0] m_byte  [2];
  logic       exp_txd [2];
  logic       exp_rdy [2];
  logic       exp_done[2];
  int         acc_cnt [2] = '{0, 0};
  int         rst_cnt [2] = '{0, 0};
  logic [7:0] sent_b  [2][128];
  int         sent_n  [2] = '{0, 0};

  function automatic int frame_len(input int i);
    return (9 + PAR + (i + 1)) * B;
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if ((PAR == 1) && (idx == 9)) return ^b;
    return 1'b1;
  endfunction

  // expected outputs for the interval following each edge
  always @(posedge clk) begin
    int o;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        if (m_in[i]) sent_n[i]--;
        m_in[i] = 1'b0;
        chk_en[i] = 1'b1;
        rst_cnt[i]++;
        exp_txd[i] = 1'b1; exp_rdy[i] = 1'b1; exp_done[i] = 1'b0;
      end else if (chk_en[i]) begin
        if (!m_in[i] && exp_rdy[i] && valid_v[i]) begin
          m_in[i] = 1'b1;
          m_t[i] = edge_n;
          m_byte[i] = data_v[i];
          sent_b[i][sent_n[i] % 128] = data_v[i];
          sent_n[i]++;
          acc_cnt[i]++;
        end
        if (m_in[i]) begin
          o = edge_n + 1 - m_t[i];
          if (o <= frame_len(i)) begin
            exp_txd[i] = frame_bit(m_byte[i], (o - 1) / B);
            exp_rdy[i] = 1'b0; exp_done[i] = 1'b0;
          end else begin
            exp_txd[i] = 1'b1; exp_rdy[i] = 1'b1; exp_done[i] = 1'b1;
            m_in[i] = 1'b0;
          end
        end else begin
          exp_txd[i] = 1'b1; exp_rdy[i] = 1'b1; exp_done[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process + line receiver ----------------
  bit         rx_act [2] = '{0, 0};
  int         rx_cnt [2] = '{0, 0};
  logic [7:0] rx_sh  [2];
  int         rx_n   [2] = '{0, 0};
  int         rx_seen[2] = '{0, 0};

  always @(negedge clk) begin
    int k;
    for (int i = 0; i < 2; i++) begin
      if (chk_en[i]) begin
        check_v("txd", i, txd_v[i], exp_txd[i]);
        check_v("tx_ready", i, ready_v[i], exp_rdy[i]);
        check_v("tx_done", i, done_v[i], exp_done[i]);
        if (rx_seen[i] != rst_cnt[i]) begin
          rx_seen[i] = rst_cnt[i];
          rx_act[i] = 1'b0;
        end
        if (!rx_act[i]) begin
          if (txd_v[i] === 1'b0) begin
            rx_act[i] = 1'b1; rx_cnt[i] = 0; rx_sh[i] = '0;
          end
        end else begin
          rx_cnt[i]++;
        end
        if (rx_act[i] && (rx_cnt[i] % B == B / 2)) begin
          k = rx_cnt[i] / B;
          if (k >= 1 && k <= 8) rx_sh[i][k-1] = txd_v[i];
          if (k == 9 + PAR) begin
            check_v("rx_byte", i, rx_sh[i], sent_b[i][rx_n[i] % 128]);
            rx_n[i]++;
            rx_act[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int i, input logic [7:0] b, input bit keep_valid);
    int c0;
    int n;
    c0 = acc_cnt[i];
    n = 0;
    @(negedge clk); #1;
    data_v[i] = b;
    valid_v[i] = 1'b1;
    while (acc_cnt[i] == c0 && n < 2000) begin @(negedge clk); n++; end
    if (acc_cnt[i] == c0) check_v("accept_timeout", i, 0, 1);
    #1;
    if (!keep_valid) valid_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((m_in[i] || !exp_rdy[i]) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check_v("idle_timeout", i, 0, 1);
  endtask

  task automatic pin_at(input int i, input int cyc, input logic v, input string nm);
    int n;
    n = 0;
    while ((edge_n + 1 < cyc) && n < 2000) begin @(negedge clk); n++; end
    if (edge_n + 1 != cyc) check_v({nm, "_late"}, i, edge_n + 1, cyc);
    else check_v(nm, i, txd_v[i], v);
  endtask

  task automatic wait_done(input int i, input int exp_off, input string nm);
    int n;
    int t;
    t = m_t[i];
    n = 0;
    while (done_v[i] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (done_v[i] !== 1'b1) check_v({nm, "_timeout"}, i, 0, 1);
    else begin
      check_v(nm, i, edge_n + 1 - t, exp_off);
      check_v({nm, "_ready"}, i, ready_v[i], 1);
    end
  endtask

  initial begin
    int t;
    rst_v = 2'b11;
    valid_v = 2'b01;
    data_v = '0;
    data_v[0] = 8'hEE;
    @(negedge clk);
    valid_v = 2'b00;
    repeat (2) @(negedge clk);
    check_v("rst_txd", 0, txd_v[0], 1);
    check_v("rst_ready", 0, ready_v[0], 1);
    check_v("rst_done", 0, done_v[0], 0);
    check_v("rst_txd", 1, txd_v[1], 1);
    #1 rst_v = 2'b00;

    // single 0x55
    send(0, 8'h55, 0);
    t = m_t[0];
    pin_at(0, t + 1, 1'b0, "start_first");
    pin_at(0, t + 8, 1'b0, "start_last");
    pin_at(0, t + 9, 1'b1, "d0");
    pin_at(0, t + 17, 1'b0, "d1");
    pin_at(0, t + 72, 1'b0, "d7");
    pin_at(0, t + 73, 1'b0 | (PAR == 0), "after_d7");
    wait_done(0, DONE0, "done_55");

    // back-to-back with tx_valid held high
    send(0, 8'hA3, 1);
    t = m_t[0];
    send(0, 8'h0F, 1);
    check_v("b2b_gap", 0, m_t[0] - t, DONE0);
    valid_v[0] = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);

    // input noise during a frame of 0x00
    send(0, 8'h00, 0);
    t = m_t[0];
    while (edge_n + 1 < t + DONE0 - 2) begin
      @(negedge clk); #1;
      valid_v[0] = 1'($urandom_range(0, 1));
      data_v[0] = (($urandom % 2) == 0) ? 8'hFF : 8'($urandom);
    end
    valid_v[0] = 1'b0;
    wait_done(0, DONE0, "done_00");

    // reset mid-frame, then a clean frame
    send(0, 8'h5A, 0);
    t = m_t[0];
    while (edge_n + 1 < t + 30) @(negedge clk);
    #1 rst_v[0] = 1'b1;
    @(negedge clk);
    check_v("midrst_txd", 0, txd_v[0], 1);
    check_v("midrst_ready", 0, ready_v[0], 1);
    check_v("midrst_done", 0, done_v[0], 0);
    #1 rst_v[0] = 1'b0;
    send(0, 8'h3C, 0);
    wait_done(0, DONE0, "done_3c");

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    valid_v[0] = 1'b0;
    wait_idle(0);

`ifdef UART_TX_PARITY_EN
    send(0, 8'h07, 0);
    t = m_t[0];
    pin_at(0, t + 73, 1'b1, "par07_first");
    pin_at(0, t + 80, 1'b1, "par07_last");
    wait_done(0, 89, "done_07");
    send(0, 8'h03, 0);
    t = m_t[0];
    pin_at(0, t + 73, 1'b0, "par03");
    wait_done(0, 89, "done_03");
`endif

    // two stop bits
    send(1, 8'h81, 0);
    t = m_t[1];
    pin_at(1, t + 9, 1'b1, "d0_81");
    pin_at(1, t + 17, 1'b0, "d1_81");
    pin_at(1, t + 72, 1'b1, "d7_81");
    pin_at(1, t + 73, (PAR == 0) ? 1'b1 : 1'b0, "after_d7_81");
    pin_at(1, t + 88, 1'b1, "stop_late_81");
    wait_done(1, DONE1, "done_81");
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(1, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    valid_v[1] = 1'b0;
    wait_idle(1);
    repeat (4) @(negedge clk);

    check_v("rx_count", 0, rx_n[0], sent_n[0]);
    check_v("rx_count", 1, rx_n[1], sent_n[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises one byte per frame onto `txd`: 1 start bit (0), 8 data bits LSB-first, optional parity, then STOP_BITS stop bits (1).
- Byte-wide valid/ready input from core-side logic (MMIO/output path).
- Bit timing uses the same CLK_PER_HALF_BIT convention as the receive side, so both ends agree on baud from one parameter.

Parameters:
CLK_PER_HALF_BIT, 5208, clock cycles per half bit; bit period B = 2*CLK_PER_HALF_BIT cycles (default gives 9600 baud at 100 MHz)
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; one clock; all logic on posedge
rst  input  1  reset; one clock; reset is synchronous and active-high
tx_data  input  8  byte to send; sampled only on the accept edge
tx_valid  input  1  byte on tx_data is offered
tx_ready  output  1  high only in S_IDLE; accept = tx_valid & tx_ready at a posedge
tx_done  output  1  one-cycle pulse when the last stop bit completes
txd  output  1  serial line, registered, idles high

Behaviour:
- Reset (rst high at a posedge): next cycle txd=1, tx_ready=1, tx_done=0, state S_IDLE, bit counter and shift register cleared.
- Reset mid-frame: the in-flight byte is dropped. The line returns high on the next cycle, which may produce a truncated frame at the receiver; this is accepted.
- States: S_IDLE, S_START, S_DATA, S_PARITY (only with the optional feature), S_STOP.
- Accept at edge T: latch tx_data into an 8-bit shift register; go to S_START; txd=0 from the cycle after T.
- Later changes on tx_data, and tx_valid while busy, are ignored.
- Bit timer: counter 0..B-1, cleared on accept. Each bit lasts exactly B cycles. The bit-end pulse fires when counter==B-1, then the counter wraps to 0.
- S_START -> S_DATA on bit end: txd = shreg[0].
- S_DATA:
  - each bit end shifts shreg right and increments a 3-bit index;
  - after index 7 finishes, go to S_STOP (or S_PARITY).
- S_STOP:
  - txd=1 for STOP_BITS*B cycles;
  - at the final bit end, go to S_IDLE and pulse tx_done in the same edge (tx_done high for the following cycle);
  - tx_ready goes high in that same following cycle.
- Frame timing with 1 stop bit, no parity:
  - start bit occupies cycles T+1..T+B;
  - data bit k occupies T+(k+1)B+1..T+(k+2)B;
  - stop bit occupies T+9B+1..T+10B;
  - tx_ready is high from cycle T+10B+1, so the earliest next accept is edge T+10B+1.
  - Back-to-back minimum period is 10B+1 cycles. The extra cycle is line-high, which is harmless.
- tx_ready is a registered-state decode (state==S_IDLE). There is no combinational path from tx_valid to tx_ready.
- Simultaneous rst and tx_valid: reset wins; nothing is accepted.
- STOP_BITS outside {1,2}: elaboration-time assertion.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - S_PARITY is inserted between S_DATA and S_STOP for B cycles;
  - txd = ^byte (even parity over the 8 latched bits, computed at accept);
  - frame is 11+ bit periods, min back-to-back period 11B+1 (STOP_BITS=1).
- Undefined: no parity state, logic or register; frame as described above.

Decomposition:
- Package uart_pkg:
  - state enum typedef (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, 3-bit encoding);
  - localparams for start/stop line levels (0/1);
  - data width 8.
- The same package is intended for reuse by the receive side.
- Sub-module uart_baud_tick:
  - parameter CLK_PER_HALF_BIT; inputs clk, rst, clear; output tick (one cycle at counter==B-1).
  - uart_tx instantiates one; clear is driven on accept.

Test Plan:
1. CLK_PER_HALF_BIT=4 (B=8), send 0x55 -> txd low exactly 8 cycles from T+1; then bits 1,0,1,0,1,0,1,0 each 8 cycles; then high; tx_done pulses once at cycle T+81; tx_ready high at T+81.
2. Send 0xA3 then 0x0F with tx_valid held high -> second accept at edge T+81; bench receiver decodes 0xA3, 0x0F; no other accepts.
3. Change tx_data to 0xFF and toggle tx_valid during a frame of 0x00 -> line carries 0x00; tx_ready stays low until end of frame.
4. Assert rst at cycle T+30 of frame 0x5A -> txd=1, tx_ready=1, tx_done=0 next cycle; a new byte 0x3C is then sent correctly.
5. STOP_BITS=2, send 0x81 -> stop high 16 cycles; tx_done at T+89.
6. With UART_TX_PARITY_EN: send 0x07 -> parity bit 1 in cycles T+73..T+80. Send 0x03 -> parity 0. tx_done at T+89 (STOP_BITS=1).
